// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional header insertion is controlled by the macro UART_ARB_HEADER_EN.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    // Default upper nibble of the per-packet header byte.
    localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // Header byte: tag nibble followed by the zero-extended grant index.
    function automatic logic [BYTE_W-1:0] make_header(input logic [3:0] tag,
                                                      input logic [3:0] id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request
// searching upward from ptr+1, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [ID_W-1:0] cand_s;

    // Scan offsets 1..N from the pointer; the first hit wins.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        cand_s = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = ID_W'((int'(ptr) + i) % N);
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit byte stream.
// Define UART_ARB_HEADER_EN to prefix each packet with a header byte
// {HEADER_TAG, grant index}.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         ID_W       = $clog2(NUM_REQ),
    parameter logic [3:0] HEADER_TAG = HEADER_TAG_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    arb_state_e          state_r, state_s;
    logic [ID_W-1:0]     grant_id_r, grant_id_s;
    logic [ID_W-1:0]     ptr_r, ptr_s;
    logic [BYTE_W-1:0]   tx_data_r, out_data_s;
    logic                tx_valid_r, out_valid_s;
    logic                load_s, accept_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                pick_found_s;
    logic                sel_valid_s, sel_last_s;
    logic [BYTE_W-1:0]   sel_data_s;
    logic [NUM_REQ-1:0]  req_ready_s;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Output register may take a new byte when empty or being drained.
    assign load_s = !tx_valid_r || tx_ready;

    // Select the granted requester's byte lane and decode per-requester ready.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        req_ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_valid_s    = sel_valid_s | ((grant_id_r == ID_W'(i)) & req_valid[i]);
            sel_last_s     = sel_last_s  | ((grant_id_r == ID_W'(i)) & req_last[i]);
            sel_data_s     = sel_data_s  | ({BYTE_W{grant_id_r == ID_W'(i)}}
                                            & req_data[i*BYTE_W +: BYTE_W]);
            req_ready_s[i] = (state_r == DATA) && (grant_id_r == ID_W'(i)) && load_s;
        end
    end

    assign accept_s = sel_valid_s && (state_r == DATA) && load_s;

    // Next-state, grant/pointer update and output-register load decision.
    always_comb begin
        state_s     = state_r;
        grant_id_s  = grant_id_r;
        ptr_s       = ptr_r;
        out_valid_s = 1'b0;
        out_data_s  = make_header(HEADER_TAG, 4'(grant_id_r));
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    grant_id_s = pick_idx_s;
`ifdef UART_ARB_HEADER_EN
                    state_s    = HDR;
`else
                    state_s    = DATA;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
`ifdef UART_ARB_HEADER_EN
                if (load_s) begin
                    out_valid_s = 1'b1;
                    state_s     = DATA;
                end else begin
                    state_s = HDR;
                end
`else
                state_s = IDLE;
`endif
            end
            DATA: begin
                if (accept_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = sel_data_s;
                    if (sel_last_s) begin
                        state_s = IDLE;
                        ptr_s   = grant_id_r;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            grant_id_r <= '0;
            ptr_r      <= ID_W'(NUM_REQ - 1);
        end else begin
            state_r    <= state_s;
            grant_id_r <= grant_id_s;
            ptr_r      <= ptr_s;
        end
    end

    // Single-entry output register toward the UART transmit side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= '0;
        end else if (load_s) begin
            tx_valid_r <= out_valid_s;
            if (out_valid_s) begin
                tx_data_r <= out_data_s;
            end
        end
    end

    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign req_ready = req_ready_s;
    assign grant_id  = grant_id_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ = 4).
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_valid, req_last, req_ready;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;
    logic [1:0]    grant_id;
    logic          busy;

    int checks = 0;
    int fails  = 0;

    // Per-requester packet byte stores {last, data}, with head/tail pointers.
    logic [8:0] pkt [NR][16];
    int         hd [NR];
    int         tl [NR];
    // Bytes seen transferring on the tx side.
    logic [7:0] got [32];
    int         ngot;

    uart_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (hd[i] < tl[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = pkt[i][hd[i]][8];
                req_data[i*8 +: 8] = pkt[i][hd[i]][7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load_byte(input int r, input logic [7:0] d, input logic l);
        pkt[r][tl[r]] = {l, d};
        tl[r]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NR; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance requesters after the rising edge.
    task automatic step();
        logic [NR-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        if (tx_valid && tx_ready && ngot < 32) begin
            got[ngot] = tx_data;
            ngot++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire[i]) hd[i]++;
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        clear_queues();
        drive_inputs();
        ngot = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic       ev [4];
        logic [7:0] ed [4];
        logic       eb [4];
        ev = '{1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{8'h00, 8'h11, 8'h22, 8'h33};
        eb = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        load_byte(1, 8'h11, 1'b0);
        load_byte(1, 8'h22, 1'b0);
        load_byte(1, 8'h33, 1'b1);
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (tx_valid !== ev[k]) begin fails++; $display("FAIL single_valid[%0d]: got %b expected %b", k, tx_valid, ev[k]); end
            if (ev[k]) begin
                checks++; if (tx_data !== ed[k]) begin fails++; $display("FAIL single_data[%0d]: got %h expected %h", k, tx_data, ed[k]); end
            end
            checks++; if (busy !== eb[k]) begin fails++; $display("FAIL single_busy[%0d]: got %b expected %b", k, busy, eb[k]); end
            if (k == 0) begin
                checks++; if (grant_id !== 2'd1) begin fails++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
            end
        end
        step();
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b expected 0", tx_valid); end
        checks++; if (ngot !== 3) begin fails++; $display("FAIL single_count: got %0d expected 3", ngot); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (got[k-1] !== ed[k]) begin fails++; $display("FAIL single_seq[%0d]: got %h expected %h", k-1, got[k-1], ed[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hD0, 8'hB0};
        do_reset();
        load_byte(0, 8'hA0, 1'b0);
        load_byte(0, 8'hA1, 1'b1);
        load_byte(2, 8'hC0, 1'b0);
        load_byte(2, 8'hC1, 1'b1);
        drive_inputs();
        step();
        checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rr_first_grant: got %0d expected 0", grant_id); end
        repeat (3) step();
        checks++; if (grant_id !== 2'd2) begin fails++; $display("FAIL rr_second_grant: got %0d expected 2", grant_id); end
        repeat (2) step();
        load_byte(0, 8'hB0, 1'b1);
        load_byte(3, 8'hD0, 1'b1);
        drive_inputs();
        step();
        checks++; if (grant_id !== 2'd3) begin fails++; $display("FAIL rr_third_grant: got %0d expected 3", grant_id); end
        repeat (2) step();
        checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rr_fourth_grant: got %0d expected 0", grant_id); end
        repeat (3) step();
        checks++; if (ngot !== 6) begin fails++; $display("FAIL rr_count: got %0d expected 6", ngot); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (got[k] !== exp_b[k]) begin fails++; $display("FAIL rr_seq[%0d]: got %h expected %h", k, got[k], exp_b[k]); end
        end
    endtask

    task automatic test_no_interleave();
        logic [7:0] exp_b [5];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10};
        do_reset();
        load_byte(0, 8'h01, 1'b0);
        load_byte(0, 8'h02, 1'b0);
        load_byte(0, 8'h03, 1'b0);
        load_byte(0, 8'h04, 1'b1);
        drive_inputs();
        repeat (2) step();
        load_byte(1, 8'h10, 1'b1);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (req_ready[1] !== 1'b0) begin fails++; $display("FAIL lock_ready1[%0d]: got %b expected 0", k, req_ready[1]); end
            checks++; if (grant_id !== 2'd0) begin fails++; $display("FAIL lock_grant[%0d]: got %0d expected 0", k, grant_id); end
        end
        step();
        checks++; if (req_ready[1] !== 1'b1) begin fails++; $display("FAIL lock_release_ready1: got %b expected 1", req_ready[1]); end
        repeat (2) step();
        checks++; if (ngot !== 5) begin fails++; $display("FAIL lock_count: got %0d expected 5", ngot); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (got[k] !== exp_b[k]) begin fails++; $display("FAIL lock_seq[%0d]: got %h expected %h", k, got[k], exp_b[k]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_b [4];
        exp_b = '{8'h21, 8'h22, 8'h23, 8'h24};
        do_reset();
        for (int k = 0; k < 4; k++) load_byte(2, exp_b[k], (k == 3));
        drive_inputs();
        repeat (2) step();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, tx_valid); end
            checks++; if (tx_data !== 8'h21) begin fails++; $display("FAIL stall_data[%0d]: got %h expected 21", k, tx_data); end
            checks++; if (req_ready[2] !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", k, req_ready[2]); end
        end
        tx_ready = 1'b1;
        repeat (6) step();
        checks++; if (ngot !== 4) begin fails++; $display("FAIL stall_count: got %0d expected 4", ngot); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp_b[k]) begin fails++; $display("FAIL stall_seq[%0d]: got %h expected %h", k, got[k], exp_b[k]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_byte(1, 8'h31, 1'b0);
        load_byte(1, 8'h32, 1'b0);
        load_byte(1, 8'h33, 1'b0);
        load_byte(1, 8'h34, 1'b1);
        drive_inputs();
        repeat (3) step();
        checks++; if (tx_data !== 8'h32) begin fails++; $display("FAIL rstmid_pre_data: got %h expected 32", tx_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b expected 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
        clear_queues();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ngot = 0;
        load_byte(3, 8'h3F, 1'b1);
        drive_inputs();
        step();
        checks++; if (grant_id !== 2'd3) begin fails++; $display("FAIL rstmid_grant: got %0d expected 3", grant_id); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_grant: got %b expected 1", busy); end
        step();
        checks++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_new_valid: got %b expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h3F) begin fails++; $display("FAIL rstmid_new_data: got %h expected 3f", tx_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_done_busy: got %b expected 0", busy); end
    endtask

    task automatic test_header();
        do_reset();
        load_byte(2, 8'h55, 1'b1);
        drive_inputs();
        step();
        checks++; if (grant_id !== 2'd2) begin fails++; $display("FAIL hdr_grant: got %0d expected 2", grant_id); end
        checks++; if (req_ready[2] !== 1'b0) begin fails++; $display("FAIL hdr_ready: got %b expected 0", req_ready[2]); end
        step();
        checks++; if (tx_data !== 8'hA2) begin fails++; $display("FAIL hdr_byte: got %h expected a2", tx_data); end
        step();
        checks++; if (tx_data !== 8'h55) begin fails++; $display("FAIL hdr_payload: got %h expected 55", tx_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hdr_busy: got %b expected 0", busy); end
    endtask

    initial begin
        tx_ready  = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        ngot      = 0;
        clear_queues();
        test_reset();
`ifdef UART_ARB_HEADER_EN
        test_header();
`else
        test_single();
        test_round_robin();
        test_no_interleave();
        test_stall();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
